// File: rtl/note_lane_scheduler.sv
// One scrolling lane of Taiko notes: on each frame tick, erase, advance, retire and spawn notes,
// then redraw them, issuing one sprite request at a time to the circle plotter.
module note_lane_scheduler #(
  parameter int unsigned MAX_NOTES  = 8,
  parameter logic [7:0]  START_X    = 8'd152,
  parameter logic [6:0]  LANE_Y     = 7'd56,
  parameter int unsigned STEP       = 1,
  parameter logic [2:0]  COLOUR_DON = 3'b100,
  parameter logic [2:0]  COLOUR_KA  = 3'b001
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic       spawn_kind,
  output logic       draw_req,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic [2:0] draw_colour,
  input  logic       draw_done,
  output logic       busy,
  output logic [4:0] active_count,
  output logic       miss_pulse,
  output logic [7:0] miss_total,
  output logic       spawn_drop,
  output logic       frame_overrun
);

  localparam int unsigned    IdxW    = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(MAX_NOTES - 1);
  localparam logic [7:0]     StepX   = 8'(STEP);
  localparam logic [7:0]     RetireX = 8'(STEP + 1);

  typedef enum logic [2:0] {
    StIdle, StEraseScan, StEraseWait, StMove, StDrawScan, StDrawWait
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [MAX_NOTES-1:0] valid_q, valid_d;
  logic [MAX_NOTES-1:0] kind_q, kind_d;
  logic [7:0]           x_q [MAX_NOTES];
  logic [7:0]           x_d [MAX_NOTES];
  logic                 tick_pend_q, tick_pend_d;
  logic                 spawn_pend_q, spawn_pend_d;
  logic                 spawn_kind_q, spawn_kind_d;
  logic                 draw_req_q, draw_req_d;
  logic [7:0]           draw_x_q, draw_x_d;
  logic [6:0]           draw_y_q, draw_y_d;
  logic [2:0]           draw_colour_q, draw_colour_d;
  logic [4:0]           active_count_q, active_count_d;
  logic                 miss_pulse_q, miss_pulse_d;
  logic [7:0]           miss_total_q, miss_total_d;
  logic                 spawn_drop_q, spawn_drop_d;
  logic                 frame_overrun_q, frame_overrun_d;

  logic [4:0]           retired;
  logic [8:0]           miss_sum;
  logic [IdxW-1:0]      free_idx;
  logic                 free_found;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    valid_d         = valid_q;
    kind_d          = kind_q;
    x_d             = x_q;
    tick_pend_d     = tick_pend_q;
    spawn_pend_d    = spawn_pend_q;
    spawn_kind_d    = spawn_kind_q;
    draw_req_d      = draw_req_q;
    draw_x_d        = draw_x_q;
    draw_y_d        = draw_y_q;
    draw_colour_d   = draw_colour_q;
    miss_pulse_d    = 1'b0;
    miss_total_d    = miss_total_q;
    spawn_drop_d    = 1'b0;
    frame_overrun_d = 1'b0;
    retired         = '0;
    miss_sum        = '0;
    free_idx        = '0;
    free_found      = 1'b0;

    if (spawn) begin
      if (spawn_pend_q) begin
        spawn_drop_d = 1'b1;
      end else begin
        spawn_pend_d = 1'b1;
        spawn_kind_d = spawn_kind;
      end
    end

    if (frame_tick && state_q != StIdle) begin
      if (tick_pend_q) frame_overrun_d = 1'b1;
      else             tick_pend_d     = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_tick || tick_pend_q) begin
          state_d     = StEraseScan;
          idx_d       = '0;
          // A direct tick arriving while a queued one is consumed becomes the new queued tick.
          tick_pend_d = tick_pend_q && frame_tick;
        end
      end
      StEraseScan, StDrawScan: begin
        if (valid_q[idx_q]) begin
          draw_req_d    = 1'b1;
          draw_x_d      = x_q[idx_q];
          draw_y_d      = LANE_Y;
          draw_colour_d = (state_q == StEraseScan) ? 3'b000 :
                          (kind_q[idx_q] ? COLOUR_KA : COLOUR_DON);
          state_d       = (state_q == StEraseScan) ? StEraseWait : StDrawWait;
        end else if (idx_q == LastIdx) begin
          state_d = (state_q == StEraseScan) ? StMove : StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StEraseWait, StDrawWait: begin
        if (draw_done) begin
          draw_req_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = (state_q == StEraseWait) ? StMove : StIdle;
            idx_d   = '0;
          end else begin
            state_d = (state_q == StEraseWait) ? StEraseScan : StDrawScan;
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end
      StMove: begin
        for (int i = 0; i < int'(MAX_NOTES); i++) begin
          if (valid_q[i]) begin
            if (x_q[i] < RetireX) begin
              valid_d[i] = 1'b0;
              retired    = retired + 5'd1;
            end else begin
              x_d[i] = x_q[i] - StepX;
            end
          end
        end
        if (retired != 5'd0) begin
          miss_pulse_d = 1'b1;
          miss_sum     = {1'b0, miss_total_q} + {4'b0000, retired};
          miss_total_d = miss_sum[8] ? 8'hff : miss_sum[7:0];
        end
        // Spawn lands in the lowest slot left free after retirement.
        if (spawn_pend_q) begin
          for (int i = int'(MAX_NOTES) - 1; i >= 0; i--) begin
            if (!valid_d[i]) begin
              free_idx   = IdxW'(i);
              free_found = 1'b1;
            end
          end
          if (free_found) begin
            valid_d[free_idx] = 1'b1;
            x_d[free_idx]     = START_X;
            kind_d[free_idx]  = spawn_kind_q;
          end else begin
            spawn_drop_d = 1'b1;
          end
          spawn_pend_d = 1'b0;
        end
        state_d = StDrawScan;
        idx_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    active_count_d = '0;
    for (int i = 0; i < int'(MAX_NOTES); i++) begin
      active_count_d = active_count_d + {4'b0000, valid_d[i]};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      valid_q         <= '0;
      kind_q          <= '0;
      for (int i = 0; i < int'(MAX_NOTES); i++) x_q[i] <= '0;
      tick_pend_q     <= 1'b0;
      spawn_pend_q    <= 1'b0;
      spawn_kind_q    <= 1'b0;
      draw_req_q      <= 1'b0;
      draw_x_q        <= '0;
      draw_y_q        <= '0;
      draw_colour_q   <= '0;
      active_count_q  <= '0;
      miss_pulse_q    <= 1'b0;
      miss_total_q    <= '0;
      spawn_drop_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      valid_q         <= valid_d;
      kind_q          <= kind_d;
      x_q             <= x_d;
      tick_pend_q     <= tick_pend_d;
      spawn_pend_q    <= spawn_pend_d;
      spawn_kind_q    <= spawn_kind_d;
      draw_req_q      <= draw_req_d;
      draw_x_q        <= draw_x_d;
      draw_y_q        <= draw_y_d;
      draw_colour_q   <= draw_colour_d;
      active_count_q  <= active_count_d;
      miss_pulse_q    <= miss_pulse_d;
      miss_total_q    <= miss_total_d;
      spawn_drop_q    <= spawn_drop_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  assign draw_req      = draw_req_q;
  assign draw_x        = draw_x_q;
  assign draw_y        = draw_y_q;
  assign draw_colour   = draw_colour_q;
  assign busy          = (state_q != StIdle);
  assign active_count  = active_count_q;
  assign miss_pulse    = miss_pulse_q;
  assign miss_total    = miss_total_q;
  assign spawn_drop    = spawn_drop_q;
  assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Bench for note_lane_scheduler: a lane model feeds a request scoreboard, a vector table drives
// spawn/frame sequences, and short hand-written sequences cover retirement, overrun and reset.
module tb_note_lane_scheduler;

  localparam int N      = 8;
  localparam int STEP   = 1;
  localparam int STARTX = 152;

  logic       clk = 1'b0;
  logic       reset, frame_tick, spawn, spawn_kind;
  logic       draw_req, busy, miss_pulse, spawn_drop, frame_overrun;
  logic [7:0] draw_x, miss_total;
  logic [6:0] draw_y;
  logic [2:0] draw_colour;
  logic [4:0] active_count;
  logic       plot_done, man_done;
  logic       draw_done;

  assign draw_done = plot_done | man_done;

  always #5 clk = ~clk;

  note_lane_scheduler dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .spawn        (spawn),
    .spawn_kind   (spawn_kind),
    .draw_req     (draw_req),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .draw_colour  (draw_colour),
    .draw_done    (draw_done),
    .busy         (busy),
    .active_count (active_count),
    .miss_pulse   (miss_pulse),
    .miss_total   (miss_total),
    .spawn_drop   (spawn_drop),
    .frame_overrun(frame_overrun)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [2:0] c;
  } req_t;

  typedef struct {
    int n_spawn;
    bit k0;
    bit k1;
    int ack;
    int exp_active;
    int exp_drop;
  } vec_t;

  req_t sb_q[$];
  vec_t vecs[11];

  int n_checks = 0;
  int n_errors = 0;

  bit m_v[N];
  int m_x[N];
  bit m_k[N];
  bit m_pend, m_kind;
  int m_total;

  bit plot_en;
  int ack_delay, wait_cnt;
  bit prev_req;
  logic [7:0] cap_x;
  logic [6:0] cap_y;
  logic [2:0] cap_c;
  int cnt_miss, cnt_drop, cnt_over;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, then update the plotter's draw_done.
  task automatic step();
    req_t e;
    @(negedge clk);
    if (draw_req && !prev_req) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_req: got x=%0d colour=%0d, expected no request",
                 draw_x, draw_colour);
      end else begin
        e = sb_q.pop_front();
        check("req_x", {24'd0, draw_x}, {24'd0, e.x});
        check("req_y", {25'd0, draw_y}, 32'd56);
        check("req_colour", {29'd0, draw_colour}, {29'd0, e.c});
      end
      cap_x = draw_x;
      cap_y = draw_y;
      cap_c = draw_colour;
    end else if (draw_req) begin
      check("req_hold", {14'd0, draw_x, draw_y, draw_colour}, {14'd0, cap_x, cap_y, cap_c});
    end
    prev_req = draw_req;
    if (miss_pulse)    cnt_miss++;
    if (spawn_drop)    cnt_drop++;
    if (frame_overrun) cnt_over++;
    plot_done = 1'b0;
    if (plot_en && draw_req) begin
      if (wait_cnt >= ack_delay) begin
        plot_done = 1'b1;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0;
      m_x[i] = 0;
      m_k[i] = 1'b0;
    end
    m_pend  = 1'b0;
    m_kind  = 1'b0;
    m_total = 0;
    sb_q.delete();
  endtask

  task automatic model_frame();
    int ret;
    int slot;
    ret = 0;
    for (int i = 0; i < N; i++) if (m_v[i]) sb_q.push_back({m_x[i][7:0], 3'b000});
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) begin
        if (m_x[i] < STEP + 1) begin
          m_v[i] = 1'b0;
          ret++;
        end else begin
          m_x[i] = m_x[i] - STEP;
        end
      end
    end
    m_total = (m_total + ret > 255) ? 255 : m_total + ret;
    if (m_pend) begin
      slot = -1;
      for (int i = 0; i < N; i++) if (!m_v[i] && slot < 0) slot = i;
      if (slot >= 0) begin
        m_v[slot] = 1'b1;
        m_x[slot] = STARTX;
        m_k[slot] = m_kind;
      end
      m_pend = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (m_v[i]) sb_q.push_back({m_x[i][7:0], m_k[i] ? 3'b001 : 3'b100});
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_spawn(input bit k);
    spawn      = 1'b1;
    spawn_kind = k;
    if (!m_pend) begin
      m_pend = 1'b1;
      m_kind = k;
    end
    step();
    spawn = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected busy=0", budget);
    end
  endtask

  task automatic do_frame(input int ack);
    ack_delay  = ack;
    frame_tick = 1'b1;
    model_frame();
    step();
    frame_tick = 1'b0;
    wait_idle(3000);
  endtask

  initial begin
    int k;
    reset = 1'b1; frame_tick = 1'b0; spawn = 1'b0; spawn_kind = 1'b0;
    plot_done = 1'b0; man_done = 1'b0;
    plot_en = 1'b1; ack_delay = 0; wait_cnt = 0; prev_req = 1'b0;
    cap_x = '0; cap_y = '0; cap_c = '0;
    cnt_miss = 0; cnt_drop = 0; cnt_over = 0;

    //            spawns k0 k1 ack active drop
    vecs[0]  = '{1, 1'b0, 1'b0, 3, 1, 0};
    vecs[1]  = '{0, 1'b0, 1'b0, 3, 1, 0};
    vecs[2]  = '{1, 1'b1, 1'b0, 0, 2, 0};
    vecs[3]  = '{2, 1'b0, 1'b1, 1, 3, 1};
    vecs[4]  = '{1, 1'b1, 1'b0, 2, 4, 0};
    vecs[5]  = '{1, 1'b0, 1'b0, 0, 5, 0};
    vecs[6]  = '{1, 1'b1, 1'b0, 1, 6, 0};
    vecs[7]  = '{1, 1'b0, 1'b0, 0, 7, 0};
    vecs[8]  = '{1, 1'b1, 1'b0, 2, 8, 0};
    vecs[9]  = '{1, 1'b0, 1'b0, 0, 8, 1};
    vecs[10] = '{0, 1'b0, 1'b0, 0, 8, 0};

    // Reset state
    do_reset(3);
    step();
    check("rst_draw_req", {31'd0, draw_req}, 0);
    check("rst_draw_x", {24'd0, draw_x}, 0);
    check("rst_draw_y", {25'd0, draw_y}, 0);
    check("rst_draw_colour", {29'd0, draw_colour}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_active", {27'd0, active_count}, 0);
    check("rst_miss_pulse", {31'd0, miss_pulse}, 0);
    check("rst_miss_total", {24'd0, miss_total}, 0);
    check("rst_spawn_drop", {31'd0, spawn_drop}, 0);
    check("rst_overrun", {31'd0, frame_overrun}, 0);

    // Table: fill the lane, including a double spawn and a spawn into a full lane
    for (int i = 0; i < 11; i++) begin
      cnt_drop = 0;
      cnt_miss = 0;
      for (int s = 0; s < vecs[i].n_spawn; s++) do_spawn(s == 0 ? vecs[i].k0 : vecs[i].k1);
      do_frame(vecs[i].ack);
      step();
      check("vec_active", {27'd0, active_count}, vecs[i].exp_active);
      check("vec_drop", cnt_drop, vecs[i].exp_drop);
      check("vec_miss", cnt_miss, 0);
      check("vec_busy", {31'd0, busy}, 0);
      check("vec_drained", sb_q.size(), 0);
    end

    // Retirement at the left edge
    do_reset(2);
    do_spawn(1'b0);
    do_frame(0);
    k = 0;
    while (m_x[0] != 1 && k < 300) begin
      do_frame(0);
      k++;
    end
    check("walk_x", m_x[0], 1);
    cnt_miss = 0;
    do_frame(0);
    step();
    check("retire_miss_pulse", cnt_miss, 1);
    check("retire_miss_total", {24'd0, miss_total}, 1);
    check("retire_active", {27'd0, active_count}, 0);
    check("retire_drained", sb_q.size(), 0);

    // Frame overrun with a slow plotter
    do_reset(2);
    do_spawn(1'b0);
    do_frame(0);
    do_spawn(1'b1);
    do_frame(0);
    cnt_over   = 0;
    ack_delay  = 20;
    frame_tick = 1'b1;
    model_frame();
    step();
    frame_tick = 1'b0;
    for (int t = 0; t < 3; t++) begin
      repeat (5) step();
      frame_tick = 1'b1;
      if (t == 0) model_frame();
      step();
      frame_tick = 1'b0;
    end
    wait_idle(3000);
    step();
    check("one_idle_cycle", {31'd0, busy}, 1);
    wait_idle(3000);
    k = 0;
    repeat (30) begin
      step();
      if (busy) k++;
    end
    check("no_third_frame", k, 0);
    check("overrun_pulses", cnt_over, 2);
    check("overrun_drained", sb_q.size(), 0);
    check("overrun_active", {27'd0, active_count}, 2);

    // Reset during DRAW_WAIT, with spawn and tick asserted in the reset cycle
    do_reset(2);
    do_spawn(1'b0);
    plot_en    = 1'b0;
    frame_tick = 1'b1;
    model_frame();
    step();
    frame_tick = 1'b0;
    k = 0;
    while (!draw_req && k < 100) begin
      step();
      k++;
    end
    check("hold_req_seen", {31'd0, draw_req}, 1);
    repeat (3) step();
    reset      = 1'b1;
    spawn      = 1'b1;
    frame_tick = 1'b1;
    step();
    spawn      = 1'b0;
    frame_tick = 1'b0;
    check("mid_rst_req", {31'd0, draw_req}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_active", {27'd0, active_count}, 0);
    check("mid_rst_x", {24'd0, draw_x}, 0);
    check("mid_rst_colour", {29'd0, draw_colour}, 0);
    reset = 1'b0;
    model_reset();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    k = 0;
    repeat (12) begin
      step();
      if (draw_req || busy) k++;
    end
    check("late_done_ignored", k, 0);
    check("late_done_y", {25'd0, draw_y}, 0);
    plot_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_lane_scheduler.md
Name: note_lane_scheduler

Overview:
- Upstream of the 7x7 circle sprite plotter. Owns one scrolling lane of Taiko notes (don/ka).
- On each frame tick: erases every live note at its old position, advances all notes left, retires notes that reach the left edge, commits any pending spawn, then redraws every live note.
- Hands the plotter one sprite request at a time over a req/done handshake (sprite top-left x/y plus colour).

Parameters:
- MAX_NOTES, 8, number of note slots (2..16)
- START_X, 152, x of a newly spawned note (sprite top-left)
- LANE_Y, 56, y of every sprite in this lane
- STEP, 1, pixels moved left per frame tick (1..7)
- COLOUR_DON, 3'b100, colour of a don note
- COLOUR_KA, 3'b001, colour of a ka note

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per display frame
- spawn  in  1  one-cycle request to add a note
- spawn_kind  in  1  0 = don, 1 = ka; sampled with spawn
- draw_req  out  1  sprite request to plotter
- draw_x  out  8  sprite top-left x
- draw_y  out  7  sprite top-left y
- draw_colour  out  3  sprite colour (3'b000 = erase)
- draw_done  in  1  plotter accepts/finishes current sprite
- busy  out  1  high whenever state != IDLE
- active_count  out  5  number of valid slots
- miss_pulse  out  1  one-cycle pulse, at least one note retired this frame
- miss_total  out  8  saturating count of retired notes
- spawn_drop  out  1  one-cycle pulse, a spawn was discarded
- frame_overrun  out  1  one-cycle pulse, a frame_tick was discarded

Behaviour:
- Reset:
  - All slots invalid; state IDLE; no pending tick and no pending spawn.
  - All outputs 0: draw_req, draw_x, draw_y, draw_colour, busy, active_count, miss_pulse, miss_total, spawn_drop, frame_overrun.
  - Reset wins over every other input in the same cycle. Reset mid-handshake drops draw_req on the next edge; any later draw_done is ignored.
- Slot state: valid bit, x (8 bit), kind bit.
- Spawn capture (any state):
  - spawn with no spawn pending: latch spawn_kind into the pending register.
  - spawn while one is already pending: the new one is discarded; spawn_drop pulses the next cycle.
- frame_tick capture:
  - In IDLE: start a frame on the next cycle.
  - While busy, no tick pending: set the pending tick.
  - While busy, tick already pending: discard; frame_overrun pulses.
  - On return to IDLE with a pending tick: clear it and start the next frame immediately (one IDLE cycle).
- FSM states:
  - IDLE: wait for a tick (direct or pending).
  - ERASE_SCAN: walk slot index 0..MAX_NOTES-1, one cycle per invalid slot. A valid slot goes to ERASE_WAIT with draw_x = slot x, draw_y = LANE_Y, draw_colour = 0, draw_req = 1. Past the last index, go to MOVE.
  - ERASE_WAIT: hold req and coordinates stable until draw_done = 1. In that cycle the request is accepted; req = 0 the next cycle and the scan resumes at index+1.
  - MOVE (exactly one cycle, all slots in parallel):
    - Valid slot with x < STEP+1: invalidated; counts as retired.
    - Otherwise: x <= x - STEP.
    - If any slot was retired: miss_pulse = 1 the next cycle; miss_total += number retired, saturating at 255.
    - Then commit the pending spawn to the lowest-index invalid slot (post-retire), with x = START_X and the latched kind.
    - If no slot is free: spawn_drop pulses and the spawn is lost. The pending spawn is cleared either way.
  - DRAW_SCAN / DRAW_WAIT: same as the erase pass, but draw_colour = COLOUR_DON or COLOUR_KA by kind. After the last index, go to IDLE.
- Handshake rules:
  - draw_done while draw_req = 0 is ignored.
  - draw_done asserted in the same cycle req rises counts as an immediate accept (1-cycle request).
  - No timeout.
- A note spawned this frame is drawn this frame and erased next frame.
- active_count is registered and updates the cycle after MOVE (and after reset).
- draw_y is always LANE_Y while req is high; outputs not under a live request hold their last value.

Test Plan:
- Reset, one spawn (kind 0) in IDLE, one frame_tick, plotter acks after 3 cycles → no erase request. One draw request: x = 152, y = 56, colour = 3'b100. active_count = 1, busy falls.
- Second frame_tick → erase request at x = 152 colour 0, then draw at x = 151 colour 3'b100. Both requests hold stable until draw_done.
- Note at x = 1 with STEP = 1, one frame_tick → erase at x = 1. Slot retired, miss_pulse for exactly 1 cycle, miss_total = 1, active_count = 0, no draw request.
- 8 notes live, spawn + frame_tick → spawn_drop pulses once, active_count stays 8. Two spawns in one frame with a free slot → second drops, first committed.
- Three frame_ticks during one long frame (plotter acks every 20 cycles) → first queued, second pulses frame_overrun. Exactly one extra frame follows after a single IDLE cycle.
- Assert reset while in DRAW_WAIT → draw_req low the next cycle. All outputs 0, state IDLE, and a late draw_done causes no request.
